// File: rtl/rom_download_sequencer.sv
// Routes HPS ioctl ROM downloads (index 0 = BIOS, 1 = font) into the BIOS/font write ports,
// holds the core in reset during and after a load, and tracks per-ROM load status.
module rom_download_sequencer #(
    parameter int BIOS_AW        = 14,
    parameter int FONT_AW        = 11,
    parameter int RELEASE_CYCLES = 16
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ext_reset,
    input  logic               ioctl_download,
    input  logic [7:0]         ioctl_index,
    input  logic               ioctl_wr,
    input  logic [24:0]        ioctl_addr,
    input  logic [7:0]         ioctl_dout,
    output logic               bios_wr,
    output logic [BIOS_AW-1:0] bios_addr,
    output logic               font_wr,
    output logic [FONT_AW-1:0] font_addr,
    output logic [7:0]         wr_data,
    output logic               core_reset,
    output logic               busy,
    output logic               bios_loaded,
    output logic               font_loaded,
    output logic               err_overflow,
    output logic [24:0]        last_len
);

    localparam int CNT_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               target_q;
    logic [24:0]        byte_cnt_q, byte_cnt_d;
    logic               core_reset_q;
    logic               bios_loaded_q, font_loaded_q, err_overflow_q;
    logic [24:0]        last_len_q;
    logic               dl_valid, load_entry, load_exit;
    logic               addr_ok, accept, reject;

    logic               vld_p1;
    logic               tgt_p1;
    logic [BIOS_AW-1:0] bios_addr_p1;
    logic [FONT_AW-1:0] font_addr_p1;
    logic [7:0]         wr_data_p1;

    function automatic logic [24:0] sat_inc(input logic [24:0] v);
        return (v == '1) ? v : v + 25'd1;
    endfunction

    function automatic logic addr_fits(input logic [24:0] a, input int aw);
        return ({1'b0, a} < (26'd1 << aw));
    endfunction

    assign dl_valid   = ioctl_download && (ioctl_index < 8'd2);
    assign addr_ok    = target_q ? addr_fits(ioctl_addr, FONT_AW) : addr_fits(ioctl_addr, BIOS_AW);
    assign accept     = (state_q == S_LOAD) && ioctl_wr && addr_ok;
    assign reject     = (state_q == S_LOAD) && ioctl_wr && !addr_ok;
    assign byte_cnt_d = accept ? sat_inc(byte_cnt_q) : byte_cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_entry = 1'b0;
        load_exit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dl_valid) begin
                    state_d    = S_LOAD;
                    load_entry = 1'b1;
                end
            end
            S_LOAD: begin
                if (!ioctl_download) begin
                    state_d   = S_HOLD;
                    cnt_d     = CNT_INIT;
                    load_exit = 1'b1;
                end
            end
            S_HOLD: begin
                // A fresh download pre-empts the release countdown
                if (dl_valid) begin
                    state_d    = S_LOAD;
                    load_entry = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!ext_reset) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q        <= S_HOLD;
            cnt_q          <= CNT_INIT;
            core_reset_q   <= 1'b1;
            target_q       <= 1'b0;
            byte_cnt_q     <= '0;
            bios_loaded_q  <= 1'b0;
            font_loaded_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            last_len_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_reset_q <= (state_d != S_IDLE) || ext_reset;
            if (load_entry) begin
                target_q       <= ioctl_index[0];
                byte_cnt_q     <= '0;
                err_overflow_q <= 1'b0;
                if (ioctl_index[0])
                    font_loaded_q <= 1'b0;
                else
                    bios_loaded_q <= 1'b0;
            end else begin
                byte_cnt_q <= byte_cnt_d;
                if (reject)
                    err_overflow_q <= 1'b1;
            end
            // The write on the falling-download cycle is already in byte_cnt_d
            if (load_exit) begin
                last_len_q <= byte_cnt_d;
                if (byte_cnt_d != '0) begin
                    if (target_q)
                        font_loaded_q <= 1'b1;
                    else
                        bios_loaded_q <= 1'b1;
                end
            end
        end
    end

    // Stage p1: registered write strobe, address and data
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            vld_p1       <= 1'b0;
            tgt_p1       <= 1'b0;
            bios_addr_p1 <= '0;
            font_addr_p1 <= '0;
            wr_data_p1   <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) begin
                tgt_p1     <= target_q;
                wr_data_p1 <= ioctl_dout;
                if (target_q)
                    font_addr_p1 <= ioctl_addr[FONT_AW-1:0];
                else
                    bios_addr_p1 <= ioctl_addr[BIOS_AW-1:0];
            end
        end
    end

    assign bios_wr      = vld_p1 && !tgt_p1;
    assign font_wr      = vld_p1 && tgt_p1;
    assign bios_addr    = bios_addr_p1;
    assign font_addr    = font_addr_p1;
    assign wr_data      = wr_data_p1;
    assign core_reset   = core_reset_q;
    assign busy         = (state_q == S_LOAD);
    assign bios_loaded  = bios_loaded_q;
    assign font_loaded  = font_loaded_q;
    assign err_overflow = err_overflow_q;
    assign last_len     = last_len_q;

endmodule

// File: tb/tb_rom_download_sequencer.sv
// Bench for rom_download_sequencer: directed tables and sequences plus random traffic,
// all checked every cycle against a behavioural model of the download rules.
module tb_rom_download_sequencer;

    localparam int RC       = 16;
    localparam int BIOS_CAP = 1 << 14;
    localparam int FONT_CAP = 1 << 11;
    localparam int M_IDLE   = 0;
    localparam int M_LOAD   = 1;
    localparam int M_HOLD   = 2;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ext_reset = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        bios_wr, font_wr, core_reset, busy, bios_loaded, font_loaded, err_overflow;
    logic [13:0] bios_addr;
    logic [10:0] font_addr;
    logic [7:0]  wr_data;
    logic [24:0] last_len;

    always #5 clk_sys = ~clk_sys;

    rom_download_sequencer dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ext_reset(ext_reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .bios_wr(bios_wr), .bios_addr(bios_addr), .font_wr(font_wr), .font_addr(font_addr),
        .wr_data(wr_data), .core_reset(core_reset), .busy(busy), .bios_loaded(bios_loaded),
        .font_loaded(font_loaded), .err_overflow(err_overflow), .last_len(last_len)
    );

    int total = 0;
    int bad = 0;
    int n_bw = 0;
    int n_fw = 0;

    // Behavioural model state
    int m_mode, m_left, m_tgt, m_count, m_last, m_baddr, m_faddr, m_data;
    bit m_bl, m_fl, m_err, m_core, m_bw, m_fw;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int cap, a;
        bit valid;
        if (!reset_n) begin
            m_mode = M_HOLD; m_left = RC - 1; m_core = 1;
            m_bw = 0; m_fw = 0; m_bl = 0; m_fl = 0; m_err = 0;
            m_baddr = 0; m_faddr = 0; m_data = 0; m_last = 0; m_count = 0; m_tgt = 0;
            return;
        end
        m_bw = 0; m_fw = 0;
        valid = ioctl_download && (ioctl_index < 2);
        a = int'(ioctl_addr);
        if (m_mode == M_LOAD) begin
            if (ioctl_wr) begin
                cap = (m_tgt == 1) ? FONT_CAP : BIOS_CAP;
                if (a < cap) begin
                    if (m_tgt == 1) begin m_fw = 1; m_faddr = a; end
                    else begin m_bw = 1; m_baddr = a; end
                    m_data = int'(ioctl_dout);
                    if (m_count < 33554431) m_count++;
                end else begin
                    m_err = 1;
                end
            end
            if (!ioctl_download) begin
                m_mode = M_HOLD; m_left = RC - 1; m_last = m_count;
                if (m_count != 0) begin
                    if (m_tgt == 1) m_fl = 1; else m_bl = 1;
                end
            end
        end else if (valid) begin
            m_mode = M_LOAD; m_tgt = int'(ioctl_index[0]); m_err = 0; m_count = 0;
            if (m_tgt == 1) m_fl = 0; else m_bl = 0;
        end else if (m_mode == M_HOLD) begin
            if (m_left > 0) m_left--;
            else if (!ext_reset) m_mode = M_IDLE;
        end
        m_core = (m_mode != M_IDLE) || ext_reset;
    endtask

    task automatic step();
        @(posedge clk_sys);
        model_edge();
        #1;
        chk("core_reset", 32'(core_reset), 32'(m_core));
        chk("busy", 32'(busy), 32'(m_mode == M_LOAD));
        chk("bios_wr", 32'(bios_wr), 32'(m_bw));
        chk("font_wr", 32'(font_wr), 32'(m_fw));
        chk("strobe_excl", 32'(bios_wr & font_wr), 32'd0);
        chk("bios_addr", 32'(bios_addr), m_baddr);
        chk("font_addr", 32'(font_addr), m_faddr);
        chk("wr_data", 32'(wr_data), m_data);
        chk("bios_loaded", 32'(bios_loaded), 32'(m_bl));
        chk("font_loaded", 32'(font_loaded), 32'(m_fl));
        chk("err_overflow", 32'(err_overflow), 32'(m_err));
        chk("last_len", 32'(last_len), m_last);
        if (bios_wr === 1'b1) n_bw++;
        if (font_wr === 1'b1) n_fw++;
    endtask

    task automatic drive(input bit rn, input bit ext, input bit dl, input int idx,
                         input bit wr, input int addr, input int dout);
        reset_n = rn; ext_reset = ext; ioctl_download = dl;
        ioctl_index = 8'(idx); ioctl_wr = wr; ioctl_addr = 25'(addr); ioctl_dout = 8'(dout);
        step();
    endtask

    // Steps with idle inputs until core_reset drops; returns the step count (bounded)
    task automatic hold_len(output int n);
        n = 0;
        do begin
            drive(1, 0, 0, 0, 0, 0, 0);
            n++;
        end while (core_reset === 1'b1 && n < 100);
    endtask

    typedef struct {
        bit dl; bit wr; int addr; int dout;
        bit e_bw; bit e_busy; bit e_core; int e_baddr; int e_data;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n, bw0, fw0;
        bit dl_r, ext_r;
        int idx_r, sel, addr;

        tbl[0] = '{1, 0, 0,       0,    0, 1, 1, 0,       0};
        tbl[1] = '{1, 1, 0,       'hA5, 1, 1, 1, 0,       'hA5};
        tbl[2] = '{1, 1, 1,       'h5A, 1, 1, 1, 1,       'h5A};
        tbl[3] = '{1, 1, 'h3FFF,  'h3C, 1, 1, 1, 'h3FFF,  'h3C};
        tbl[4] = '{0, 0, 0,       0,    0, 0, 1, 'h3FFF,  'h3C};

        // Reset: three cycles low, then count the release hold
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        hold_len(n);
        chk("rst_release_len", n, RC);

        // BIOS load from the vector table
        bw0 = n_bw; fw0 = n_fw;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, tbl[i].dl, 0, tbl[i].wr, tbl[i].addr, tbl[i].dout);
            chk("tbl_bios_wr", 32'(bios_wr), 32'(tbl[i].e_bw));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
            chk("tbl_core_reset", 32'(core_reset), 32'(tbl[i].e_core));
            chk("tbl_bios_addr", 32'(bios_addr), tbl[i].e_baddr);
            chk("tbl_wr_data", 32'(wr_data), tbl[i].e_data);
        end
        chk("bios_last_len", 32'(last_len), 32'd3);
        chk("bios_loaded_set", 32'(bios_loaded), 32'd1);
        chk("bios_no_err", 32'(err_overflow), 32'd0);
        hold_len(n);
        chk("bios_release_len", n, RC);
        chk("bios_strobes", n_bw - bw0, 3);
        chk("bios_no_font_wr", n_fw - fw0, 0);

        // Font overflow: 0x7FF accepted, 0x800 rejected
        fw0 = n_fw;
        drive(1, 0, 1, 1, 0, 0, 0);
        drive(1, 0, 1, 1, 1, 'h7FF, 'h11);
        drive(1, 0, 1, 1, 1, 'h800, 'h22);
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("ovf_font_strobes", n_fw - fw0, 1);
        chk("ovf_font_addr", 32'(font_addr), 32'h7FF);
        chk("ovf_err", 32'(err_overflow), 32'd1);
        chk("ovf_last_len", 32'(last_len), 32'd1);
        chk("ovf_font_loaded", 32'(font_loaded), 32'd1);
        hold_len(n);

        // Empty font download, then an ignored index=2 download
        drive(1, 0, 1, 1, 0, 0, 0);
        drive(1, 0, 1, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("empty_font_loaded", 32'(font_loaded), 32'd0);
        chk("empty_last_len", 32'(last_len), 32'd0);
        hold_len(n);
        bw0 = n_bw; fw0 = n_fw;
        drive(1, 0, 1, 2, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 2, 1, i, 'h40 + i);
            chk("ign_core_reset", 32'(core_reset), 32'd0);
            chk("ign_busy", 32'(busy), 32'd0);
        end
        drive(1, 0, 0, 2, 0, 0, 0);
        chk("ign_strobes", (n_bw - bw0) + (n_fw - fw0), 0);

        // Reset in the middle of a BIOS load
        drive(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 0, 1, 0, 1, 'h100 + i, i);
        drive(0, 0, 0, 0, 1, 'h200, 'h77);
        chk("mid_bios_loaded", 32'(bios_loaded), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        bw0 = n_bw;
        hold_len(n);
        chk("mid_release_len", n, RC);
        chk("mid_no_strobes", n_bw - bw0, 0);

        // Re-download five cycles into HOLD, then ext_reset past the count
        drive(1, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 1, 5, 'h99);
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0);
        chk("redl_busy", 32'(busy), 32'd1);
        chk("redl_bios_cleared", 32'(bios_loaded), 32'd0);
        chk("redl_core_reset", 32'(core_reset), 32'd1);
        drive(1, 0, 1, 0, 1, 6, 'h98);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            if (core_reset !== 1'b1) n++;
        end
        chk("ext_hold_lows", n, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("ext_release", 32'(core_reset), 32'd0);

        // Random traffic against the model
        dl_r = 0; ext_r = 0; idx_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                dl_r = !dl_r;
                sel = $urandom_range(0, 5);
                idx_r = (sel < 2) ? 0 : (sel < 4) ? 1 : (sel == 4) ? 2 : 200;
            end
            if ($urandom_range(0, 39) == 0) ext_r = !ext_r;
            case ($urandom_range(0, 3))
                0: addr = $urandom_range(0, 100);
                1: addr = $urandom_range(2040, 2060);
                2: addr = $urandom_range(16370, 16400);
                default: addr = int'($urandom & 32'h01FF_FFFF);
            endcase
            drive($urandom_range(0, 299) != 0, ext_r, dl_r, idx_r,
                  1'($urandom_range(0, 1)), addr, int'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
